// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory path: loader state
// encoding, memory geometry and the opcode constants the decoder also uses.
package imem_pkg;

  localparam int IMEM_DEPTH  = 8;
  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b11;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CKSUM = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a program byte stream over valid/ready,
// drives the memory write port and holds the core in reset until the whole
// program has landed in memory.
//
// Optional build macro IMEM_LOADER_CKSUM_EN: after the s_last beat one extra
// checksum beat is taken; the load only succeeds if the sum of all program
// bytes plus that beat is zero (mod 256).
//
// state | meaning
// LOAD  | accepting program bytes, writing each one to memory
// CKSUM | waiting for the trailing checksum beat (checksum build only)
// FLUSH | final write is on the port; core still held
// DONE  | program loaded, core released
// ERR   | overflow or checksum mismatch; core held until reload/reset
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reload,
  input  logic               s_valid,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W-1:0]  byte_count
);

  // Top address; the count ceiling is clipped to what byte_count can hold.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam int COUNT_MAX_I = (DEPTH < (1 << ADDR_W)) ? DEPTH : (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] COUNT_MAX = ADDR_W'(COUNT_MAX_I);

  imem_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              load_accept;
  logic              cksum_ok;

  // A reload in the same cycle wins over any presented beat.
  assign s_ready     = ((state == LOAD) || (state == CKSUM)) && !reload;
  assign accept      = s_valid && s_ready;
  assign load_accept = accept && (state == LOAD);

  assign core_hold = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERR);

`ifdef IMEM_LOADER_CKSUM_EN
  logic [INSTR_W-1:0] sum;
  logic [INSTR_W-1:0] sum_total;

  assign sum_total = sum + s_data;
  assign cksum_ok  = (sum_total == '0);

  // Running mod-256 sum of program bytes; the checksum beat itself is excluded.
  always_ff @(posedge clk) begin
    if (!reset || reload) sum <= '0;
    else if (load_accept) sum <= sum + s_data;
  end
`else
  assign cksum_ok = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state decode; overflow is flagged only when the byte at the top
  // address is not the last one, so a full-depth program is still legal.
  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (s_last) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state_nxt = CKSUM;
`else
              state_nxt = FLUSH;
`endif
            end else if (cnt == LAST_ADDR) begin
              state_nxt = ERR;
            end
          end
        end
        CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
          if (accept) state_nxt = cksum_ok ? FLUSH : ERR;
`else
          state_nxt = ERR;
`endif
        end
        FLUSH:   state_nxt = DONE;
        DONE:    state_nxt = DONE;
        ERR:     state_nxt = ERR;
        default: state_nxt = ERR;
      endcase
    end
  end

  // Write port, address counter and byte count; cnt stops at the top
  // address so it can never wrap back onto already-written locations.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cnt        <= '0;
      byte_count <= '0;
    end else begin
      wr_en <= load_accept;
      if (load_accept) begin
        wr_addr <= cnt;
        wr_data <= s_data;
        if (cnt != LAST_ADDR)        cnt        <= cnt + ADDR_W'(1);
        if (byte_count != COUNT_MAX) byte_count <= byte_count + ADDR_W'(1);
      end
      if (reload) begin
        cnt        <= '0;
        byte_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized program loads.
// Expectations come from the loader's externally visible rules: every
// accepted beat shows up on the write port one cycle later at the next
// address, the core is released two cycles after the final accept, and a
// full-depth stream with no last marker is an error.
module tb_imem_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              reload = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] byte_count;

  int vectors = 0;
  int miscompares = 0;

`ifdef IMEM_LOADER_CKSUM_EN
  int cks_force = -1;
`endif

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a program, one beat per cycle when valid; checks the write that
  // each accept must produce and the end-of-load outcome.
  task automatic stream(input logic [7:0] prog[$], input bit with_last, input int mode);
    int         idx = 0;
    int         budget = 0;
    bit         v;
    bit         ph = 1'b1;
    logic [7:0] sum = 8'h00;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] cks;
    logic [7:0] tot;
`endif
    while (idx < prog.size()) begin
      if (budget > 200) begin
        chk("stream_budget", idx, prog.size());
        s_valid = 1'b0;
        return;
      end
      budget++;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = !ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      reload  = 1'b0;
      s_valid = v;
      s_data  = v ? prog[idx] : 8'($urandom);
      s_last  = v ? (with_last && (idx == prog.size() - 1)) : 1'($urandom_range(0, 1));
      #1;
      chk("s_ready_load", s_ready, 1);
      tick();
      if (v) begin
        chk("wr_en_accept", wr_en, 1);
        chk("wr_addr", wr_addr, idx);
        chk("wr_data", wr_data, prog[idx]);
        chk("byte_count_run", byte_count, idx + 1);
        sum = sum + prog[idx];
        idx++;
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (with_last) begin
`ifdef IMEM_LOADER_CKSUM_EN
      cks = (cks_force < 0) ? 8'(8'h00 - sum) : 8'(cks_force);
      tot = sum + cks;
      s_valid = 1'b1;
      s_data  = cks;
      #1;
      chk("s_ready_cksum", s_ready, 1);
      tick();
      s_valid = 1'b0;
      chk("wr_en_cksum", wr_en, 0);
      if (tot != 8'h00) begin
        chk("cksum_err", load_err, 1);
        chk("cksum_hold", core_hold, 1);
        chk("cksum_done", load_done, 0);
        chk("cksum_ready", s_ready, 0);
        return;
      end
`endif
      chk("flush_hold", core_hold, 1);
      chk("flush_ready", s_ready, 0);
      tick();
      chk("release_hold", core_hold, 0);
      chk("done", load_done, 1);
      chk("done_err", load_err, 0);
      chk("done_wr_en", wr_en, 0);
      chk("done_count", byte_count, prog.size());
    end else if (prog.size() == DEPTH) begin
      chk("ovf_err", load_err, 1);
      chk("ovf_hold", core_hold, 1);
      chk("ovf_done", load_done, 0);
      chk("ovf_ready", s_ready, 0);
      chk("ovf_count", byte_count, DEPTH);
    end
  endtask

  // Reload with a beat offered in the same cycle; that beat must be refused.
  task automatic do_reload();
    reload  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    s_last  = 1'($urandom_range(0, 1));
    #1;
    chk("reload_ready", s_ready, 0);
    tick();
    reload  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("reload_wr_en", wr_en, 0);
    chk("reload_hold", core_hold, 1);
    chk("reload_done", load_done, 0);
    chk("reload_err", load_err, 0);
    chk("reload_count", byte_count, 0);
  endtask

  // Beats offered after the load finished must be ignored.
  task automatic offer_ignored(input int n, input int count_exp);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom_range(0, 1));
      #1;
      chk("ignored_ready", s_ready, 0);
      tick();
      chk("ignored_wr_en", wr_en, 0);
      chk("ignored_count", byte_count, count_exp);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    logic [7:0] prog[$];
    logic [7:0] p2[$];
    int         len;
    bit         lst;

    // Reset values.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hold", core_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_count", byte_count, 0);
    reset = 1'b1;
    #1;
    chk("rst_ready", s_ready, 1);

    // Six-byte program, back-to-back beats.
    prog = '{8'h25, 8'h61, 8'h2C, 8'hC1, 8'h6B, 8'h1D};
    stream(prog, 1'b1, 0);
    offer_ignored(3, 6);

    // Reload from DONE, then the same program with valid toggling.
    do_reload();
    stream(prog, 1'b1, 1);

    // Full depth without a last marker overflows.
    do_reload();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(8'($urandom));
    stream(prog, 1'b0, 0);
    offer_ignored(2, DEPTH);

    // Full depth with last on the top address is a legal program.
    do_reload();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(8'($urandom));
    stream(prog, 1'b1, 0);

    // Reset in the middle of a load, then a fresh 2-byte program.
    do_reload();
    prog = '{8'h11, 8'h22, 8'h33};
    stream(prog, 1'b0, 0);
    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h44;
    tick();
    reset   = 1'b1;
    s_valid = 1'b0;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_addr", wr_addr, 0);
    chk("midrst_count", byte_count, 0);
    chk("midrst_hold", core_hold, 1);
    p2 = '{8'h5A, 8'hA5};
    stream(p2, 1'b1, 0);
    chk("midrst_final_count", byte_count, 2);

    // One-byte program.
    do_reload();
    p2 = '{8'h7E};
    stream(p2, 1'b1, 1);

`ifdef IMEM_LOADER_CKSUM_EN
    // Explicit checksum beats: matching then mismatching.
    do_reload();
    p2 = '{8'h10, 8'h20};
    cks_force = 8'hD0;
    stream(p2, 1'b1, 0);
    do_reload();
    cks_force = 8'hD1;
    stream(p2, 1'b1, 0);
    cks_force = -1;
`endif

    // Randomized loads from ERR or DONE, random lengths and valid patterns.
    for (int n = 0; n < 12; n++) begin
      do_reload();
      len = $urandom_range(1, DEPTH);
      lst = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      prog = {};
      for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      stream(prog, lst, 2);
      if (!lst) offer_ignored(1, DEPTH);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 8-bit instruction memory. Accepts a program byte stream over a valid/ready interface and drives the memory's synchronous write port.
- Holds the core in reset until the load completes, then releases it.
- Sits between the boot/debug byte source and the instruction memory write port.

Parameters:
- DEPTH, 8, number of instruction memory locations; legal range 2..256.
- ADDR_W, 8, width of the write address; must match the PC width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low
- reload  input  1  single-cycle request to restart loading from address 0
- s_valid  input  1  stream beat valid
- s_data  input  8  program byte (one instruction)
- s_last  input  1  marks the final program byte
- s_ready  output  1  loader can accept a beat
- wr_en  output  1  memory write strobe, registered
- wr_addr  output  ADDR_W  memory write address, registered
- wr_data  output  8  memory write data, registered
- core_hold  output  1  holds the core in reset while 1
- load_done  output  1  program loaded successfully
- load_err  output  1  overflow, or checksum fail when the optional feature is enabled
- byte_count  output  ADDR_W  number of bytes accepted in the current load

Behaviour:
- Reset: reset is synchronous and active-low. When reset==0 at a clk edge:
  - state=LOAD, cnt=0
  - wr_en=0, wr_addr=0, wr_data=0
  - core_hold=1, load_done=0, load_err=0, byte_count=0
  - s_ready may be 1 in the first cycle after reset.
- Reset mid-load is honoured in any state. Memory contents are not cleared.
- States:
  - LOAD: s_ready=1. A beat is accepted when s_valid&&s_ready at the edge.
    - On accept: wr_en=1, wr_addr=cnt, wr_data=s_data (all visible the next cycle); cnt and byte_count increment.
    - If s_last: go to FLUSH.
    - Else if cnt==DEPTH-1: the byte is still written, then go to ERR (overflow).
  - FLUSH: one cycle. s_ready=0 and wr_en is still showing the final write. Next state is DONE.
  - DONE: s_ready=0, core_hold=0, load_done=1. wr_en=0 from here on.
  - ERR: s_ready=0, core_hold=1, load_err=1, load_done=0.
- wr_en is a one-cycle pulse per accepted beat. Back-to-back beats give a continuous wr_en with consecutive addresses.
- Latency:
  - Accept to wr_en: 1 cycle.
  - Final accept to core_hold falling: 2 cycles. This guarantees the last write lands before the core fetches.
- reload=1 in any state (reset inactive):
  - Next state is LOAD with cnt=0, byte_count=0, core_hold=1, load_done=0, load_err=0, wr_en=0.
  - A beat presented in the same cycle as reload is NOT accepted; s_ready is forced to 0 that cycle.
- s_last on the first beat is legal: a 1-byte program.
- cnt never wraps. Overflow always goes to ERR.
- Beats presented in FLUSH, DONE or ERR are ignored (s_ready=0).
- byte_count saturates at DEPTH.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN
- Defined:
  - An 8-bit running sum (mod 256) of all program bytes is kept.
  - After the s_last beat, the loader enters state CKSUM with s_ready=1 and accepts exactly one more beat. That beat is not written to memory.
  - If sum+beat==8'h00: go to FLUSH, then DONE.
  - Otherwise: go to ERR with load_err=1.
  - The sum clears on reset and on reload.
- Not defined: the CKSUM state and the sum register do not exist; s_last goes straight to FLUSH.

Decomposition:
- Shared package (imem_pkg):
  - state encoding constants: LOAD, CKSUM, FLUSH, DONE, ERR
  - IMEM_DEPTH=8, IMEM_ADDR_W=8, INSTR_W=8
  - opcode constants shared with the decoder: 2'b00 add, 2'b01 sll, 2'b11 jump
- No sub-module needed: a single FSM plus counter. The optional checksum accumulator stays inline.

Test Plan:
- Reset then stream 6 bytes 8'h25,8'h61,8'h2C,8'hC1,8'h6B,8'h1D (last on 8'h1D) with s_valid always 1:
  - wr_en high for 6 consecutive cycles, addresses 0..5
  - core_hold falls 2 cycles after the 8'h1D accept
  - load_done=1, byte_count=6
- Same stream with s_valid toggling every other cycle: identical memory writes and addresses, no duplicated or skipped beats.
- 8 bytes without s_last (DEPTH=8): addresses 0..7 written, then load_err=1, core_hold stays 1, s_ready=0.
- Drive reset=0 after the 3rd byte, then re-stream 2 bytes (last on 2nd): wr_addr restarts at 0, byte_count=2, load_done=1.
- From DONE, pulse reload with s_valid=1 in the same cycle: that beat is not accepted, core_hold=1, load_done=0, next accepted beat goes to address 0.
- With IMEM_LOADER_CKSUM_EN defined, bytes 8'h10,8'h20 (last):
  - checksum beat 8'hD0 gives load_done=1 and no wr_en for the checksum beat
  - checksum beat 8'hD1 gives load_err=1 and core_hold=1
